// File: rtl/food_level_scheduler_if.sv
// Signal bundle between the pet controller and food_level_scheduler.
// LEVEL_FORCE_EN adds force_valid/force_level for direct level loading.
interface food_level_scheduler_if;
   logic       feed_req;
   logic       test_mode;
   logic       pause;
   logic [1:0] level;
   logic       feeding;
   logic       level_changed;
   logic       starving;
   logic       tick;
`ifdef LEVEL_FORCE_EN
   logic       force_valid;
   logic [1:0] force_level;

   modport master (
      output feed_req, test_mode, pause, force_valid, force_level,
      input  level, feeding, level_changed, starving, tick
   );
   modport slave (
      input  feed_req, test_mode, pause, force_valid, force_level,
      output level, feeding, level_changed, starving, tick
   );
`else
   modport master (
      output feed_req, test_mode, pause,
      input  level, feeding, level_changed, starving, tick
   );
   modport slave (
      input  feed_req, test_mode, pause,
      output level, feeding, level_changed, starving, tick
   );
`endif
endinterface

// File: rtl/food_level_scheduler.sv
// Pet food level: prescaled decay, held-button feeding, starvation flag.
// Define LEVEL_FORCE_EN to enable force_valid/force_level direct loading.
module food_level_scheduler #(
   parameter int unsigned TICK_DIV      = 50000000,
   parameter int unsigned TEST_TICK_DIV = 50000,
   parameter int unsigned DECAY_TICKS   = 30,
   parameter int unsigned FEED_TICKS    = 2,
   parameter int unsigned STARVE_TICKS  = 10
) (
   input logic                   clk,
   input logic                   reset,
   food_level_scheduler_if.slave bus
);

   localparam int unsigned MAX_A = (TICK_DIV > TEST_TICK_DIV) ? TICK_DIV : TEST_TICK_DIV;
   localparam int unsigned MAX_B = (DECAY_TICKS > FEED_TICKS) ? DECAY_TICKS : FEED_TICKS;
   localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned MAXP  = (MAX_C > STARVE_TICKS) ? MAX_C : STARVE_TICKS;
   localparam int unsigned CW    = $clog2(MAXP + 1);

   localparam logic [CW-1:0] DECAY_LAST  = CW'(DECAY_TICKS - 1);
   localparam logic [CW-1:0] FEED_LAST   = CW'(FEED_TICKS - 1);
   localparam logic [CW-1:0] STARVE_MAX  = CW'(STARVE_TICKS);
   localparam logic [CW-1:0] NORM_LAST   = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] TEST_LAST   = CW'(TEST_TICK_DIV - 1);

   localparam logic [1:0] ST_DECAY = 2'd0;
   localparam logic [1:0] ST_FEED  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic          test_mode_q;
   logic [CW-1:0] presc_cnt;
   logic          tick_q;
   logic [CW-1:0] div_last;

   logic [1:0]    state, state_nxt;
   logic [1:0]    level_q, level_nxt;
   logic [CW-1:0] decay_cnt, decay_nxt;
   logic [CW-1:0] feed_cnt, feed_nxt;
   logic [CW-1:0] starve_cnt, starve_nxt;
   logic          feeding_q;
   logic          level_changed_q;

   assign div_last = test_mode_q ? TEST_LAST : NORM_LAST;

   // A test_mode edge restarts the prescaler so the new rate starts from a clean phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         test_mode_q <= 1'b0;
         presc_cnt   <= '0;
         tick_q      <= 1'b0;
      end else begin
         test_mode_q <= bus.test_mode;
         if (bus.test_mode != test_mode_q) begin
            presc_cnt <= '0;
            tick_q    <= 1'b0;
         end else if (presc_cnt == div_last) begin
            presc_cnt <= '0;
            tick_q    <= 1'b1;
         end else begin
            presc_cnt <= presc_cnt + CW'(1);
            tick_q    <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      level_nxt = level_q;
      decay_nxt = decay_cnt;
      feed_nxt  = feed_cnt;
      case (state)
         ST_DECAY: begin
            // Button edges win over a coincident tick: no decay on the transition cycle.
            if (bus.feed_req) begin
               if (level_q != 2'd3) begin
                  state_nxt = ST_FEED;
                  feed_nxt  = '0;
               end else begin
                  state_nxt = ST_HOLD;
               end
            end else if (tick_q && !bus.pause) begin
               if (decay_cnt == DECAY_LAST) begin
                  decay_nxt = '0;
                  if (level_q != 2'd0) level_nxt = level_q - 2'd1;
               end else begin
                  decay_nxt = decay_cnt + CW'(1);
               end
            end
         end
         ST_FEED: begin
            if (!bus.feed_req) begin
               state_nxt = ST_DECAY;
            end else if (level_q == 2'd3) begin
               state_nxt = ST_HOLD;
            end else if (tick_q) begin
               if (feed_cnt == FEED_LAST) begin
                  feed_nxt  = '0;
                  level_nxt = level_q + 2'd1;
                  if (level_q == 2'd2) state_nxt = ST_HOLD;
               end else begin
                  feed_nxt = feed_cnt + CW'(1);
               end
            end
         end
         ST_HOLD: begin
            if (!bus.feed_req) begin
               state_nxt = ST_DECAY;
               decay_nxt = '0;
            end
         end
         default: state_nxt = ST_DECAY;
      endcase

      if (level_nxt != 2'd0)
         starve_nxt = '0;
      else if (tick_q && level_q == 2'd0 && starve_cnt != STARVE_MAX)
         starve_nxt = starve_cnt + CW'(1);
      else
         starve_nxt = starve_cnt;

`ifdef LEVEL_FORCE_EN
      if (bus.force_valid) begin
         state_nxt  = ST_DECAY;
         level_nxt  = bus.force_level;
         decay_nxt  = '0;
         feed_nxt   = '0;
         starve_nxt = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= ST_DECAY;
         level_q         <= 2'd3;
         decay_cnt       <= '0;
         feed_cnt        <= '0;
         starve_cnt      <= '0;
         feeding_q       <= 1'b0;
         level_changed_q <= 1'b0;
      end else begin
         state           <= state_nxt;
         level_q         <= level_nxt;
         decay_cnt       <= decay_nxt;
         feed_cnt        <= feed_nxt;
         starve_cnt      <= starve_nxt;
         feeding_q       <= (state_nxt == ST_FEED);
         level_changed_q <= (level_nxt != level_q);
      end
   end

   assign bus.level         = level_q;
   assign bus.feeding       = feeding_q;
   assign bus.level_changed = level_changed_q;
   assign bus.starving      = (starve_cnt == STARVE_MAX);
   assign bus.tick          = tick_q;

endmodule

// File: tb/tb_food_level_scheduler.sv
// Directed bench for food_level_scheduler with a shortened timebase.
// Expected values are hand-derived edge counts from reset release.
module tb_food_level_scheduler;
   logic clk;
   logic reset;
   int   nvec;
   int   nerr;
   int   lc_seen;
   int   feed_seen;
   int   snap;

   food_level_scheduler_if bus ();

   food_level_scheduler #(
      .TICK_DIV      (4),
      .TEST_TICK_DIV (2),
      .DECAY_TICKS   (3),
      .FEED_TICKS    (2),
      .STARVE_TICKS  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs sampled in the active region of posedge hold the value of the cycle just ended.
   always @(posedge clk) begin
      if (bus.level_changed === 1'b1) lc_seen++;
      if (bus.feeding === 1'b1) feed_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n active edges, returning at the following negedge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
   endtask

   initial begin
      nvec = 0; nerr = 0; lc_seen = 0; feed_seen = 0; snap = 0;
      reset = 1'b0;
      bus.feed_req = 1'b0; bus.test_mode = 1'b0; bus.pause = 1'b0;
`ifdef LEVEL_FORCE_EN
      bus.force_valid = 1'b0; bus.force_level = 2'd0;
`endif
      cyc(2);
      check("rst_level", 32'(bus.level), 32'd3);
      check("rst_feeding", 32'(bus.feeding), 32'd0);
      check("rst_lc", 32'(bus.level_changed), 32'd0);
      check("rst_starving", 32'(bus.starving), 32'd0);
      check("rst_tick", 32'(bus.tick), 32'd0);
      reset = 1'b1;

      // Decay: ticks land on edges 4k+1, every third one decrements.
      cyc(12); check("dec_e12_level", 32'(bus.level), 32'd3);
      cyc(1);  check("dec_e13_level", 32'(bus.level), 32'd2);
      check("dec_e13_lc", 32'(bus.level_changed), 32'd1);
      cyc(12); check("dec_e25_level", 32'(bus.level), 32'd1);
      cyc(12); check("dec_e37_level", 32'(bus.level), 32'd0);
      cyc(7);  check("starve_e44", 32'(bus.starving), 32'd0);
      cyc(1);  check("starve_e45", 32'(bus.starving), 32'd1);
      cyc(24); check("no_underflow", 32'(bus.level), 32'd0);
      check("lc_count_decay", 32'(lc_seen), 32'd3);
      check("starve_sat", 32'(bus.starving), 32'd1);

      // Feeding from level 1 up to HOLD.
      do_reset();
      cyc(25); check("feed_start_level", 32'(bus.level), 32'd1);
      bus.feed_req = 1'b1;
      cyc(1);  check("feed_e26_feeding", 32'(bus.feeding), 32'd1);
      cyc(6);  check("feed_e32_level", 32'(bus.level), 32'd1);
      cyc(1);  check("feed_e33_level", 32'(bus.level), 32'd2);
      check("feed_e33_lc", 32'(bus.level_changed), 32'd1);
      cyc(7);  check("feed_e40_feeding", 32'(bus.feeding), 32'd1);
      cyc(1);  check("feed_e41_level", 32'(bus.level), 32'd3);
      check("hold_feeding", 32'(bus.feeding), 32'd0);
      snap = lc_seen + 1;
      cyc(40); check("hold_level", 32'(bus.level), 32'd3);
      check("hold_no_lc", 32'(lc_seen), 32'(snap));
      bus.feed_req = 1'b0;
      cyc(11); check("hold_rel_e92", 32'(bus.level), 32'd3);
      cyc(1);  check("hold_rel_e93", 32'(bus.level), 32'd2);

      // Pause with decay_cnt=1 freezes, then resumes from 1.
      cyc(4);
      bus.pause = 1'b1;
      snap = lc_seen;
      cyc(100); check("pause_level", 32'(bus.level), 32'd2);
      check("pause_no_lc", 32'(lc_seen), 32'(snap));
      bus.pause = 1'b0;
      cyc(7);  check("unpause_e204", 32'(bus.level), 32'd2);
      cyc(1);  check("unpause_e205", 32'(bus.level), 32'd1);

      // test_mode switch clears the prescaler and doubles the tick rate.
      do_reset();
      cyc(2);
      bus.test_mode = 1'b1;
      cyc(1);  check("tm_e3_tick", 32'(bus.tick), 32'd0);
      cyc(1);  check("tm_e4_tick", 32'(bus.tick), 32'd0);
      cyc(1);  check("tm_e5_tick", 32'(bus.tick), 32'd1);
      cyc(4);  check("tm_e9_level", 32'(bus.level), 32'd3);
      cyc(1);  check("tm_e10_level", 32'(bus.level), 32'd2);

      // Async reset mid-feed at level 1, feed_cnt 1.
      cyc(6);  check("mid_e16_level", 32'(bus.level), 32'd1);
      bus.feed_req = 1'b1;
      cyc(2);  check("mid_e18_feeding", 32'(bus.feeding), 32'd1);
      check("mid_e18_level", 32'(bus.level), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_level", 32'(bus.level), 32'd3);
      check("async_feeding", 32'(bus.feeding), 32'd0);
      check("async_starving", 32'(bus.starving), 32'd0);

      // feed_req at level 3 in the same cycle as a tick that would decrement.
      bus.feed_req = 1'b0;
      bus.test_mode = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(12); check("coin_tick", 32'(bus.tick), 32'd1);
      bus.feed_req = 1'b1;
      snap = feed_seen;
      cyc(1);  check("coin_level", 32'(bus.level), 32'd3);
      check("coin_lc", 32'(bus.level_changed), 32'd0);
      cyc(10); check("coin_hold_level", 32'(bus.level), 32'd3);
      check("coin_never_fed", 32'(feed_seen), 32'(snap));
      bus.feed_req = 1'b0;
      cyc(2);

`ifdef LEVEL_FORCE_EN
      bus.force_level = 2'd0;
      bus.force_valid = 1'b1;
      cyc(1);  check("force_level", 32'(bus.level), 32'd0);
      check("force_lc", 32'(bus.level_changed), 32'd1);
      check("force_starving0", 32'(bus.starving), 32'd0);
      bus.force_valid = 1'b0;
      cyc(9);  check("force_starving", 32'(bus.starving), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
